// File: rtl/sweep_pkg.sv
// sweep_pkg: shared types for the S-parameter sweep sequencer
// state encoding, record layout and accumulator width helper
package sweep_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TUNE,
        ST_SETTLE,
        ST_ACQ,
        ST_EMIT,
        ST_DONE
    } state_t;

    localparam int DEF_NPTS = 64;
    localparam int DEF_DW   = 12;
    localparam int DEF_IW   = $clog2(DEF_NPTS);

    typedef struct packed {
        logic [DEF_IW-1:0]        idx;
        logic                     port;
        logic signed [DEF_DW-1:0] a;
        logic signed [DEF_DW-1:0] refl;
        logic signed [DEF_DW-1:0] thru;
    } rec_t;

    function automatic int accw(input int dw, input int navg_log2);
        return dw + navg_log2;
    endfunction

endpackage

// File: rtl/sweep_accum.sv
// sweep_accum: three signed full-precision accumulators
// plus a sample counter that flags the last sample of a record
module sweep_accum import sweep_pkg::*; #(
    parameter int DW        = 12,
    parameter int NAVG_LOG2 = 3,
    parameter int AW        = accw(DW, NAVG_LOG2)
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 en,
    input  logic signed [DW-1:0] a,
    input  logic signed [DW-1:0] b1,
    input  logic signed [DW-1:0] b2,
    output logic signed [AW-1:0] sum_a,
    output logic signed [AW-1:0] sum_b1,
    output logic signed [AW-1:0] sum_b2,
    output logic                 last
);

    localparam int CW = NAVG_LOG2 + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << NAVG_LOG2) - 1);

    logic [CW-1:0] cnt;
    logic          take;

    assign take = en && !last;

    // sum samples until the last one is in, then hold
    always_ff @(posedge clk) begin
        if (clr) begin
            sum_a  <= '0;
            sum_b1 <= '0;
            sum_b2 <= '0;
            cnt    <= '0;
            last   <= 1'b0;
        end else if (take) begin
            sum_a  <= sum_a  + {{NAVG_LOG2{a[DW-1]}}, a};
            sum_b1 <= sum_b1 + {{NAVG_LOG2{b1[DW-1]}}, b1};
            sum_b2 <= sum_b2 + {{NAVG_LOG2{b2[DW-1]}}, b2};
            cnt    <= cnt + CW'(1);
            last   <= (cnt == CNT_LAST);
        end
    end

endmodule

// File: rtl/sparam_sweep_sequencer.sv
// sparam_sweep_sequencer: steps the source through the frequency list,
// alternates P1/P2 excitation and streams one averaged record per port
module sparam_sweep_sequencer import sweep_pkg::*; #(
    parameter int NPTS      = 64,
    parameter int SETTLE    = 16,
    parameter int NAVG_LOG2 = 3,
    parameter int DW        = 12,
    parameter int FW        = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [FW-1:0]              f_start,
    input  logic [FW-1:0]              f_step,
    output logic                       busy,
    output logic                       done,
    output logic [FW-1:0]              freq_word,
    output logic                       freq_load,
    output logic                       port_sel,
    output logic                       rf_en,
    input  logic                       adc_valid,
    input  logic signed [DW-1:0]       adc_a,
    input  logic signed [DW-1:0]       adc_b1,
    input  logic signed [DW-1:0]       adc_b2,
    output logic                       rec_valid,
    input  logic                       rec_ready,
    output logic [$clog2(NPTS)-1:0]    rec_idx,
    output logic                       rec_port,
    output logic signed [DW-1:0]       rec_a,
    output logic signed [DW-1:0]       rec_refl,
    output logic signed [DW-1:0]       rec_thru
);

    localparam int IW = $clog2(NPTS);
    localparam int AW = accw(DW, NAVG_LOG2);
    localparam int SW = $clog2(SETTLE + 1);

    state_t               state;
    logic [FW-1:0]        step;
    logic [IW-1:0]        idx;
    logic [SW-1:0]        scnt;
    logic                 acc_clr;
    logic                 acc_en;
    logic                 acc_last;
    logic signed [AW-1:0] sum_a;
    logic signed [AW-1:0] sum_b1;
    logic signed [AW-1:0] sum_b2;

    // accumulators only run in ACQ and restart fresh for every record
    assign acc_clr  = rst || (state != ST_ACQ);
    assign acc_en   = (state == ST_ACQ) && adc_valid;
    assign rec_idx  = idx;
    assign rec_port = port_sel;

    sweep_accum #(
        .DW        (DW),
        .NAVG_LOG2 (NAVG_LOG2),
        .AW        (AW)
    ) u_accum (
        .clk    (clk),
        .clr    (acc_clr),
        .en     (acc_en),
        .a      (adc_a),
        .b1     (adc_b1),
        .b2     (adc_b2),
        .sum_a  (sum_a),
        .sum_b1 (sum_b1),
        .sum_b2 (sum_b2),
        .last   (acc_last)
    );

    // sweep control with registered outputs; abort overrides any handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            freq_word <= '0;
            freq_load <= 1'b0;
            port_sel  <= 1'b0;
            rf_en     <= 1'b0;
            rec_valid <= 1'b0;
            rec_a     <= '0;
            rec_refl  <= '0;
            rec_thru  <= '0;
            idx       <= '0;
            step      <= '0;
            scnt      <= '0;
        end else if (abort && state != ST_IDLE) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            freq_load <= 1'b0;
            rf_en     <= 1'b0;
            rec_valid <= 1'b0;
        end else begin
            freq_load <= 1'b0;
            done      <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        state     <= ST_TUNE;
                        busy      <= 1'b1;
                        freq_word <= f_start;
                        step      <= f_step;
                        freq_load <= 1'b1;
                        rf_en     <= 1'b1;
                        idx       <= '0;
                        port_sel  <= 1'b0;
                    end
                end
                ST_TUNE: begin
                    scnt  <= '0;
                    state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (scnt == SW'(SETTLE - 1)) begin
                        scnt  <= '0;
                        state <= ST_ACQ;
                    end else begin
                        scnt <= scnt + SW'(1);
                    end
                end
                ST_ACQ: begin
                    if (acc_last) begin
                        rec_a     <= DW'(sum_a  >>> NAVG_LOG2);
                        rec_refl  <= DW'(sum_b1 >>> NAVG_LOG2);
                        rec_thru  <= DW'(sum_b2 >>> NAVG_LOG2);
                        rec_valid <= 1'b1;
                        state     <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (rec_ready) begin
                        rec_valid <= 1'b0;
                        if (!port_sel) begin
                            port_sel <= 1'b1;
                            scnt     <= '0;
                            state    <= ST_SETTLE;
                        end else if (idx != IW'(NPTS - 1)) begin
                            idx       <= idx + IW'(1);
                            freq_word <= freq_word + step;
                            freq_load <= 1'b1;
                            rf_en     <= 1'b1;
                            port_sel  <= 1'b0;
                            state     <= ST_TUNE;
                        end else begin
                            done  <= 1'b1;
                            rf_en <= 1'b0;
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
